// File: rtl/lcd_capture.sv
// ----------------------------------------------------------------------------
// lcd_capture
//
// Receives the LCD pixel stream produced by video_controller and rebuilds each
// frame in a linear framebuffer. Four 2-bit pixels are packed into one byte.
// The first pixel of a group lands in bits [7:6]. Each completed byte is
// presented on a one-cycle write port. Line and frame geometry are checked,
// and good or bad frames are reported.
//
// Ports:
//   clock        system clock, all inputs synchronous to it
//   reset        synchronous active-high reset
//   capture_en   arms capture, sampled at each vsync rising edge
//   pixel_data   2-bit pixel shade, valid with pixel_latch
//   pixel_latch  one-cycle strobe per pixel
//   hsync        rising edge closes the current line
//   vsync        rising edge marks a frame boundary
//   fb_addr      framebuffer byte address
//   fb_data      packed byte
//   fb_we        one-cycle write strobe
//   frame_done   pulse: a frame with correct geometry completed
//   frame_err    pulse: a frame ended with bad geometry
//   line_err     sticky: a short or long line was seen since reset
//   frame_count  count of good frames, wraps 255 -> 0
//   busy         high while capturing
// ----------------------------------------------------------------------------
module lcd_capture #(
    parameter int H_PIXELS = 160,
    parameter int V_LINES  = 144,
    parameter int ADDR_W   = 13
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              capture_en,
    input  logic [1:0]        pixel_data,
    input  logic              pixel_latch,
    input  logic              hsync,
    input  logic              vsync,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [7:0]        fb_data,
    output logic              fb_we,
    output logic              frame_done,
    output logic              frame_err,
    output logic              line_err,
    output logic [7:0]        frame_count,
    output logic              busy
);

    localparam int XW = $clog2(H_PIXELS + 1);
    localparam int YW = $clog2(V_LINES + 2);

    localparam logic [XW-1:0]     LP_XMAX   = XW'(H_PIXELS);
    localparam logic [YW-1:0]     LP_YMAX   = YW'(V_LINES);
    localparam logic [YW-1:0]     LP_YSAT   = YW'(V_LINES + 1);
    localparam logic [ADDR_W-1:0] LP_STRIDE = ADDR_W'(H_PIXELS / 4);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_CAPTURE = 1'b1;

    logic [0:0]        r_state;
    logic              r_hsCur, r_hsPrev, r_vsCur, r_vsPrev;
    logic [XW-1:0]     r_x;
    logic [YW-1:0]     r_y;
    logic [5:0]        r_shift;
    logic [ADDR_W-1:0] r_lineBase;
    logic              r_badLine;
    logic [ADDR_W-1:0] r_fbAddr;
    logic [7:0]        r_fbData;
    logic              r_fbWe;
    logic              r_frameDone;
    logic              r_frameErr;
    logic              r_lineErr;
    logic [7:0]        r_frameCount;

    logic          w_hsEdge, w_vsEdge, w_capturing;
    logic          w_accept, w_long, w_groupFull;
    logic          w_lineEnd, w_short, w_flush;
    logic [XW-1:0] w_xNext;
    logic [5:0]    w_shiftNext;
    logic [7:0]    w_flushData;

    assign w_hsEdge    = r_hsCur & ~r_hsPrev;
    assign w_vsEdge    = r_vsCur & ~r_vsPrev;
    assign w_capturing = (r_state == ST_CAPTURE);

    // Per-cycle decisions. A pixel arriving with an hsync edge is folded in
    // first, so the line-end and flush logic see the post-pixel x and shift
    // values. A vsync edge blocks both the pixel and the line end.
    always_comb begin
        w_accept    = w_capturing && pixel_latch && !w_vsEdge &&
                      (r_y < LP_YMAX) && (r_x < LP_XMAX);
        w_long      = w_capturing && pixel_latch && !w_vsEdge &&
                      (r_y < LP_YMAX) && (r_x >= LP_XMAX);
        w_xNext     = w_accept ? (r_x + XW'(1)) : r_x;
        w_shiftNext = w_accept ? {r_shift[3:0], pixel_data} : r_shift;
        w_groupFull = w_accept && (r_x[1:0] == 2'd3);
        w_lineEnd   = w_capturing && w_hsEdge && !w_vsEdge;
        w_short     = w_lineEnd && (w_xNext < LP_XMAX);
        w_flush     = w_lineEnd && (w_xNext[1:0] != 2'd0);
        // A partial group is left-aligned; the missing low pixels read as 0.
        w_flushData = 8'h00;
        case (w_xNext[1:0])
            2'd1:    w_flushData = {w_shiftNext[1:0], 6'b0};
            2'd2:    w_flushData = {w_shiftNext[3:0], 4'b0};
            2'd3:    w_flushData = {w_shiftNext[5:0], 2'b0};
            default: w_flushData = 8'h00;
        endcase
    end

    // Main sequential block. It registers the sync inputs and the write port,
    // and it holds the line and frame bookkeeping. The vsync handling comes
    // last, so its clears win over anything the line logic did this cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_hsCur      <= 1'b0;
            r_hsPrev     <= 1'b0;
            r_vsCur      <= 1'b0;
            r_vsPrev     <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_shift      <= '0;
            r_lineBase   <= '0;
            r_badLine    <= 1'b0;
            r_fbAddr     <= '0;
            r_fbData     <= '0;
            r_fbWe       <= 1'b0;
            r_frameDone  <= 1'b0;
            r_frameErr   <= 1'b0;
            r_lineErr    <= 1'b0;
            r_frameCount <= '0;
        end else begin
            r_hsCur     <= hsync;
            r_hsPrev    <= r_hsCur;
            r_vsCur     <= vsync;
            r_vsPrev    <= r_vsCur;
            r_fbWe      <= 1'b0;
            r_frameDone <= 1'b0;
            r_frameErr  <= 1'b0;

            // A full group uses the pre-increment x for its address. A flush
            // uses the post-pixel x, which still points into the partial group.
            if (w_groupFull) begin
                r_fbWe   <= 1'b1;
                r_fbAddr <= r_lineBase + ADDR_W'(r_x >> 2);
                r_fbData <= {r_shift, pixel_data};
            end else if (w_flush) begin
                r_fbWe   <= 1'b1;
                r_fbAddr <= r_lineBase + ADDR_W'(w_xNext >> 2);
                r_fbData <= w_flushData;
            end

            if (w_long || w_short) begin
                r_lineErr <= 1'b1;
                r_badLine <= 1'b1;
            end

            r_x     <= w_xNext;
            r_shift <= w_shiftNext;

            if (w_lineEnd) begin
                r_x <= '0;
                if (r_y < LP_YSAT) begin
                    r_y        <= r_y + YW'(1);
                    r_lineBase <= r_lineBase + LP_STRIDE;
                end
            end

            if (w_vsEdge) begin
                if (w_capturing) begin
                    if ((r_y == LP_YMAX) && !r_badLine) begin
                        r_frameDone  <= 1'b1;
                        r_frameCount <= r_frameCount + 8'd1;
                    end else begin
                        r_frameErr <= 1'b1;
                    end
                end
                r_x        <= '0;
                r_y        <= '0;
                r_shift    <= '0;
                r_lineBase <= '0;
                r_badLine  <= 1'b0;
                r_state    <= capture_en ? ST_CAPTURE : ST_IDLE;
            end
        end
    end

    assign fb_addr     = r_fbAddr;
    assign fb_data     = r_fbData;
    assign fb_we       = r_fbWe;
    assign frame_done  = r_frameDone;
    assign frame_err   = r_frameErr;
    assign line_err    = r_lineErr;
    assign frame_count = r_frameCount;
    assign busy        = w_capturing;

endmodule
